// File: rtl/register_file_if.sv
// Register-file access bundle: write port plus two read ports.
// The datapath side uses the master modport and the storage uses the slave modport.
interface register_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  reg_write;
  logic [ADDR_WIDTH-1:0] dirA;
  logic [ADDR_WIDTH-1:0] dirB;
  logic [ADDR_WIDTH-1:0] dir_WR;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] datA;
  logic [DATA_WIDTH-1:0] datB;

  modport master (
    output reg_write, dirA, dirB, dir_WR, data_in,
    input  datA, datB
  );

  modport slave (
    input  reg_write, dirA, dirB, dir_WR, data_in,
    output datA, datB
  );
endinterface

// File: rtl/register_file.sv
// CalcuTEC general-purpose register file: 2**ADDR_WIDTH x DATA_WIDTH storage.
// It has two combinational read ports and one rising-edge write port, and address 0 is writable.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  register_file_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];

  always_comb begin
    regs_d = regs_q;
    if (bus.reg_write) begin
      regs_d[bus.dir_WR] = bus.data_in;
    end
  end

  // The asynchronous clear wins over any write edge that arrives while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // The read ports have no bypass. A same-address write appears only after its edge.
  assign bus.datA = regs_q[bus.dirA];
  assign bus.datB = regs_q[bus.dirB];
endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file.
// Each read pushes reference values into a scoreboard queue, and the values are popped and compared once the ports settle.
module tb_register_file;
  localparam int DW = 32;
  localparam int AW = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [DW-1:0] model [16];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] ea;
  logic [DW-1:0] eb;

  register_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the write port at the falling edge. Update the reference model just after the rising edge it commits on.
  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    @(negedge clk);
    bus.reg_write = 1'b1;
    bus.dir_WR    = addr;
    bus.data_in   = data;
    @(posedge clk);
    #1;
    if (rst_n) model[addr] = data;
  endtask

  task automatic drive_read(input logic [AW-1:0] a, input logic [AW-1:0] b);
    bus.dirA = a;
    bus.dirB = b;
    exp_q.push_back(model[a]);
    exp_q.push_back(model[b]);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) model[i] = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_model();
    drive_read(4'd0, 4'd15);
    #1;
    ea = exp_q.pop_front(); eb = exp_q.pop_front();
    checks += 2;
    if (bus.datA !== ea) begin errors++; $display("[TB] FAIL in_reset_A got %h exp %h", bus.datA, ea); end
    if (bus.datB !== eb) begin errors++; $display("[TB] FAIL in_reset_B got %h exp %h", bus.datB, eb); end
    #19;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive_read(i[AW-1:0], i[AW-1:0]);
      #1;
      ea = exp_q.pop_front(); eb = exp_q.pop_front();
      checks += 2;
      if (bus.datA !== ea) begin errors++; $display("[TB] FAIL reset_A[%0d] got %h exp %h", i, bus.datA, ea); end
      if (bus.datB !== eb) begin errors++; $display("[TB] FAIL reset_B[%0d] got %h exp %h", i, bus.datB, eb); end
    end
  endtask

  task automatic test_sequential_write();
    logic [DW-1:0] vals [11];
    vals = '{32'd1, 32'd12, 32'd123, 32'd1234, 32'd2345, 32'd3456,
             32'd4567, 32'd5678, 32'd6789, 32'd12345, 32'd23456};
    for (int i = 0; i < 11; i++) do_write(i[AW-1:0], vals[i]);
    @(negedge clk);
    bus.reg_write = 1'b0;
    for (int i = 0; i < 16; i += 2) begin
      @(negedge clk);
      drive_read(i[AW-1:0], AW'(i + 1));
      #1;
      ea = exp_q.pop_front(); eb = exp_q.pop_front();
      checks += 2;
      if (bus.datA !== ea) begin errors++; $display("[TB] FAIL seq_A[%0d] got %0d exp %0d", i, bus.datA, ea); end
      if (bus.datB !== eb) begin errors++; $display("[TB] FAIL seq_B[%0d] got %0d exp %0d", i + 1, bus.datB, eb); end
    end
    @(negedge clk);
    bus.dirA = 4'd10;
    #1;
    checks++;
    if (bus.datA !== 32'd23456) begin errors++; $display("[TB] FAIL seq_const10 got %0d exp 23456", bus.datA); end
  endtask

  task automatic test_write_disable();
    @(negedge clk);
    bus.reg_write = 1'b0;
    bus.dir_WR    = 4'd3;
    bus.data_in   = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    drive_read(4'd3, 4'd3);
    #1;
    ea = exp_q.pop_front(); eb = exp_q.pop_front();
    checks += 2;
    if (bus.datA !== ea) begin errors++; $display("[TB] FAIL wdis_A got %h exp %h", bus.datA, ea); end
    if (bus.datA !== 32'd1234) begin errors++; $display("[TB] FAIL wdis_1234 got %0d exp 1234", bus.datA); end
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    bus.reg_write = 1'b1;
    bus.dir_WR    = 4'd5;
    bus.data_in   = 32'hA5A5A5A5;
    drive_read(4'd5, 4'd5);
    #1;
    ea = exp_q.pop_front(); eb = exp_q.pop_front();
    checks += 2;
    if (bus.datA !== ea) begin errors++; $display("[TB] FAIL same_pre_A got %h exp %h", bus.datA, ea); end
    if (bus.datB !== eb) begin errors++; $display("[TB] FAIL same_pre_B got %h exp %h", bus.datB, eb); end
    @(posedge clk);
    #1;
    model[5] = 32'hA5A5A5A5;
    drive_read(4'd5, 4'd5);
    #0;
    ea = exp_q.pop_front(); eb = exp_q.pop_front();
    checks += 2;
    if (bus.datA !== ea) begin errors++; $display("[TB] FAIL same_post_A got %h exp %h", bus.datA, ea); end
    if (bus.datB !== eb) begin errors++; $display("[TB] FAIL same_post_B got %h exp %h", bus.datB, eb); end
    @(negedge clk);
    bus.reg_write = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    clear_model();
    drive_read(4'd5, 4'd3);
    #1;
    ea = exp_q.pop_front(); eb = exp_q.pop_front();
    checks += 2;
    if (bus.datA !== ea) begin errors++; $display("[TB] FAIL arst_A got %h exp %h", bus.datA, ea); end
    if (bus.datB !== eb) begin errors++; $display("[TB] FAIL arst_B got %h exp %h", bus.datB, eb); end
    do_write(4'd5, 32'h12345678);
    @(negedge clk);
    bus.reg_write = 1'b0;
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    drive_read(4'd5, 4'd0);
    #1;
    ea = exp_q.pop_front(); eb = exp_q.pop_front();
    checks += 2;
    if (bus.datA !== ea) begin errors++; $display("[TB] FAIL arst_wr5 got %h exp %h", bus.datA, ea); end
    if (bus.datB !== eb) begin errors++; $display("[TB] FAIL arst_r0 got %h exp %h", bus.datB, eb); end
  endtask

  task automatic test_max();
    do_write(4'd14, 32'h0F0F0F0F);
    do_write(4'd15, 32'hFFFFFFFF);
    @(negedge clk);
    bus.reg_write = 1'b0;
    drive_read(4'd14, 4'd15);
    #1;
    ea = exp_q.pop_front(); eb = exp_q.pop_front();
    checks += 2;
    if (bus.datA !== ea) begin errors++; $display("[TB] FAIL max_a14 got %h exp %h", bus.datA, ea); end
    if (bus.datB !== eb) begin errors++; $display("[TB] FAIL max_b15 got %h exp %h", bus.datB, eb); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) do_write(i[AW-1:0], $urandom());
    @(negedge clk);
    bus.reg_write = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive_read(i[AW-1:0], AW'(15 - i));
      #1;
      ea = exp_q.pop_front(); eb = exp_q.pop_front();
      checks += 2;
      if (bus.datA !== ea) begin errors++; $display("[TB] FAIL b2b_A[%0d] got %h exp %h", i, bus.datA, ea); end
      if (bus.datB !== eb) begin errors++; $display("[TB] FAIL b2b_B[%0d] got %h exp %h", 15 - i, bus.datB, eb); end
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.reg_write = 1'b0;
    bus.dirA      = '0;
    bus.dirB      = '0;
    bus.dir_WR    = '0;
    bus.data_in   = '0;
    test_reset();
    test_sequential_write();
    test_write_disable();
    test_same_cycle();
    test_async_reset();
    test_max();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL scoreboard_drain got %0d exp 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
